// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave in front of a word-organised SRAM: programmable wait states,
// little-endian byte/half/word lanes and a two-cycle ERROR response.
module ahb_sram_slave #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [1:0]            HTRANS,
    input  logic                  HREADY,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP
);
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

    state_t                state;
    logic [3:0]            cnt;
    logic                  valid_q;
    logic                  write_q;
    logic [1:0]            size_q;
    logic [IDX_W+1:0]      addr_q;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                  addr_slot;
    logic                  accept;
    logic                  acc_err;
    logic                  commit;
    logic                  no_wait;
    logic                  load_early;
    logic                  load_late;
    logic [ADDR_WIDTH-3:0] word_addr;
    logic [IDX_W-1:0]      wr_idx;
    logic [IDX_W-1:0]      rd_idx;
    logic [3:0]            be;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  unused_inputs;

    assign unused_inputs = ^{HBURST, HTRANS[0]};
    assign no_wait       = (WAIT_STATES == 0);
    assign word_addr     = HADDR[ADDR_WIDTH-1:2];
    assign addr_slot     = (state == ST_IDLE) || (state == ST_ERR2);
    assign accept        = HSEL & HREADY & HTRANS[1] & addr_slot;

    always_comb begin
        acc_err = 1'b0;
        if (HSIZE > 3'd2)
            acc_err = 1'b1;
        if (HSIZE == 3'd1 && HADDR[0])
            acc_err = 1'b1;
        if (HSIZE == 3'd2 && HADDR[1:0] != 2'b00)
            acc_err = 1'b1;
        if (word_addr >= (ADDR_WIDTH-2)'(MEM_DEPTH))
            acc_err = 1'b1;
    end

    // A pending OKAY write completes in the IDLE cycle that follows its wait states.
    assign commit = valid_q & write_q & (state == ST_IDLE);
    assign wr_idx = addr_q[IDX_W+1:2];

    always_comb begin
        case (size_q)
            2'd0:    be = 4'b0001 << addr_q[1:0];
            2'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    assign load_early = accept & ~acc_err & ~HWRITE & no_wait;
    assign load_late  = (state == ST_WAIT) & (cnt == 4'd0) & ~write_q;
    assign rd_idx     = load_late ? addr_q[IDX_W+1:2] : HADDR[IDX_W+1:2];

    // Bytes of a write committing on the same edge are forwarded into the read word.
    always_comb begin
        rd_word = mem[rd_idx];
        if (commit && wr_idx == rd_idx) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b])
                    rd_word[8*b +: 8] = HWDATA[8*b +: 8];
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESET && commit) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b])
                    mem[wr_idx][8*b +: 8] <= HWDATA[8*b +: 8];
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            valid_q   <= 1'b0;
            write_q   <= 1'b0;
            size_q    <= 2'd0;
            addr_q    <= '0;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
            HRDATA    <= '0;
        end else begin
            if (load_early || load_late)
                HRDATA <= rd_word;
            case (state)
                ST_IDLE, ST_ERR2: begin
                    if (accept) begin
                        addr_q  <= HADDR[IDX_W+1:0];
                        write_q <= HWRITE;
                        size_q  <= HSIZE[1:0];
                        if (acc_err) begin
                            state     <= ST_ERR1;
                            valid_q   <= 1'b0;
                            HREADYOUT <= 1'b0;
                            HRESP     <= 1'b1;
                        end else if (WAIT_STATES > 0) begin
                            state     <= ST_WAIT;
                            cnt       <= 4'(WAIT_STATES - 1);
                            valid_q   <= 1'b1;
                            HREADYOUT <= 1'b0;
                            HRESP     <= 1'b0;
                        end else begin
                            state     <= ST_IDLE;
                            valid_q   <= 1'b1;
                            HREADYOUT <= 1'b1;
                            HRESP     <= 1'b0;
                        end
                    end else begin
                        state     <= ST_IDLE;
                        valid_q   <= 1'b0;
                        HREADYOUT <= 1'b1;
                        HRESP     <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) begin
                        state     <= ST_IDLE;
                        HREADYOUT <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_ERR1: begin
                    state     <= ST_ERR2;
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b1;
                end
                default: begin
                    state     <= ST_IDLE;
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: one instance with no wait states and one with three,
// both checked against a word-array model of the memory and last read data.
module tb_ahb_sram_slave;
    localparam int DEPTH = 1024;
    localparam int NW    = 64;

    logic        hclk = 1'b0;
    logic        hreset;
    logic [1:0]  hsel;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [1:0]  htrans;
    logic [31:0] rdata0, rdata3;
    logic        rdy0, rdy3;
    logic        resp0, resp3;

    logic [31:0] mdl [2][NW];
    logic [31:0] last_rd [2];
    int vectors = 0;
    int miscompares = 0;

    always #5 hclk = ~hclk;

    ahb_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
        .HCLK(hclk), .HRESET(hreset), .HSEL(hsel[0]), .HADDR(haddr), .HWDATA(hwdata),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HTRANS(htrans), .HREADY(rdy0),
        .HRDATA(rdata0), .HREADYOUT(rdy0), .HRESP(resp0));

    ahb_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(DEPTH), .WAIT_STATES(3)) dut3 (
        .HCLK(hclk), .HRESET(hreset), .HSEL(hsel[1]), .HADDR(haddr), .HWDATA(hwdata),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HTRANS(htrans), .HREADY(rdy3),
        .HRDATA(rdata3), .HREADYOUT(rdy3), .HRESP(resp3));

    function automatic logic get_rdy(input int t);
        return (t == 0) ? rdy0 : rdy3;
    endfunction
    function automatic logic get_resp(input int t);
        return (t == 0) ? resp0 : resp3;
    endfunction
    function automatic logic [31:0] get_rdata(input int t);
        return (t == 0) ? rdata0 : rdata3;
    endfunction
    function automatic int ws_of(input int t);
        return (t == 0) ? 0 : 3;
    endfunction

    function automatic bit exp_err(input logic [31:0] a, input logic [2:0] sz);
        if (sz > 3'd2) return 1'b1;
        if ((a % (32'd1 << sz)) != 32'd0) return 1'b1;
        return (a >> 2) >= 32'(DEPTH);
    endfunction

    function automatic void mdl_write(input int t, input logic [31:0] a, input logic [2:0] sz,
                                      input logic [31:0] wd);
        int w;
        bit en;
        w = int'(a >> 2);
        for (int b = 0; b < 4; b++) begin
            case (sz)
                3'd0:    en = (b == int'(a % 4));
                3'd1:    en = ((b / 2) == int'((a / 2) % 2));
                default: en = 1'b1;
            endcase
            if (en) mdl[t][w][8*b +: 8] = wd[8*b +: 8];
        end
    endfunction

    task automatic addr_phase(input int t, input bit wr, input logic [31:0] a, input logic [2:0] sz);
        hsel    = 2'b00;
        hsel[t] = 1'b1;
        haddr   = a;
        hwrite  = wr;
        hsize   = sz;
        htrans  = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b11;
        hburst  = 3'($urandom_range(0, 7));
    endtask

    // Both slaves stay selected but see IDLE/BUSY, which must have no effect.
    task automatic bus_idle();
        hsel   = 2'b11;
        htrans = 2'($urandom_range(0, 1));
        haddr  = $urandom;
        hwrite = ($urandom_range(0, 1) == 1);
        hsize  = 3'($urandom_range(0, 2));
    endtask

    task automatic wait_ready(input int t, output bit ok, output int waits, output int err_waits);
        ok = 1'b0;
        waits = 0;
        err_waits = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge hclk);
            if (get_rdy(t) === 1'b1) begin
                ok = 1'b1;
                break;
            end
            waits++;
            if (get_resp(t) === 1'b1) err_waits++;
        end
    endtask

    task automatic xfer(input int t, input bit wr, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, output logic [31:0] rd, output bit rsp,
                        output int waits, output int err_waits, output bit ok);
        addr_phase(t, wr, a, sz);
        @(posedge hclk); #1;
        bus_idle();
        hwdata = wd;
        wait_ready(t, ok, waits, err_waits);
        rd  = get_rdata(t);
        rsp = get_resp(t);
        @(posedge hclk); #1;
        hwdata = $urandom;
    endtask

    // Write immediately followed by a pipelined word read.
    task automatic b2b(input int t, input logic [31:0] wa, input logic [2:0] wsz, input logic [31:0] wd,
                       input logic [31:0] ra, output bit w_rsp, output int w_waits,
                       output logic [31:0] rd, output bit r_rsp, output int r_waits, output bit ok);
        int ew;
        bit ok1, ok2;
        addr_phase(t, 1'b1, wa, wsz);
        @(posedge hclk); #1;
        hwdata = wd;
        addr_phase(t, 1'b0, ra, 3'd2);
        wait_ready(t, ok1, w_waits, ew);
        w_rsp = get_resp(t);
        @(posedge hclk); #1;
        bus_idle();
        hwdata = $urandom;
        wait_ready(t, ok2, r_waits, ew);
        rd    = get_rdata(t);
        r_rsp = get_resp(t);
        @(posedge hclk); #1;
        ok = ok1 & ok2;
    endtask

    task automatic test_reset();
        hreset = 1'b1;
        bus_idle();
        hwdata = 32'd0;
        repeat (3) @(posedge hclk);
        #1 hreset = 1'b0;
        @(negedge hclk);
        for (int t = 0; t < 2; t++) begin
            vectors++;
            if (get_rdy(t) !== 1'b1 || get_resp(t) !== 1'b0 || get_rdata(t) !== 32'd0) begin
                miscompares++;
                $display("FAIL reset dut%0d: got ready=%b resp=%b rdata=%h, want 1 0 00000000",
                         t, get_rdy(t), get_resp(t), get_rdata(t));
            end
            last_rd[t] = 32'd0;
        end
        @(posedge hclk); #1;
    endtask

    task automatic test_init();
        logic [31:0] wd, rd;
        bit rsp, ok;
        int waits, ew;
        for (int t = 0; t < 2; t++) begin
            for (int w = 0; w < NW; w++) begin
                wd = $urandom;
                xfer(t, 1'b1, 32'(w * 4), 3'd2, wd, rd, rsp, waits, ew, ok);
                mdl_write(t, 32'(w * 4), 3'd2, wd);
                vectors++;
                if (!ok || rsp !== 1'b0 || waits != ws_of(t) || rd !== last_rd[t]) begin
                    miscompares++;
                    $display("FAIL init dut%0d word %0d: got ok=%b resp=%b waits=%0d rdata=%h, want 1 0 %0d %h",
                             t, w, ok, rsp, waits, rd, ws_of(t), last_rd[t]);
                end
            end
        end
    endtask

    task automatic test_word_rw();
        logic [31:0] rd;
        bit rsp, ok;
        int waits, ew;
        xfer(0, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF, rd, rsp, waits, ew, ok);
        mdl_write(0, 32'h10, 3'd2, 32'hDEADBEEF);
        vectors++;
        if (!ok || rsp !== 1'b0 || waits != 0) begin
            miscompares++;
            $display("FAIL word_write: got ok=%b resp=%b waits=%0d, want 1 0 0", ok, rsp, waits);
        end
        xfer(0, 1'b0, 32'h10, 3'd2, $urandom, rd, rsp, waits, ew, ok);
        vectors++;
        if (!ok || rsp !== 1'b0 || waits != 0 || rd !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL word_read: got ok=%b resp=%b waits=%0d rdata=%h, want 1 0 0 deadbeef",
                     ok, rsp, waits, rd);
        end
        last_rd[0] = 32'hDEADBEEF;
    endtask

    task automatic test_lanes();
        logic [31:0] rd, wb, wh;
        bit rsp, ok;
        int waits, ew;
        for (int t = 0; t < 2; t++) begin
            wb = ($urandom & 32'hFFFF00FF) | 32'h0000AA00;
            wh = ($urandom & 32'h0000FFFF) | 32'h55660000;
            xfer(t, 1'b1, 32'h20, 3'd2, 32'h0, rd, rsp, waits, ew, ok);
            xfer(t, 1'b1, 32'h21, 3'd0, wb, rd, rsp, waits, ew, ok);
            xfer(t, 1'b1, 32'h22, 3'd1, wh, rd, rsp, waits, ew, ok);
            mdl_write(t, 32'h20, 3'd2, 32'h0);
            mdl_write(t, 32'h21, 3'd0, wb);
            mdl_write(t, 32'h22, 3'd1, wh);
            xfer(t, 1'b0, 32'h20, 3'd2, $urandom, rd, rsp, waits, ew, ok);
            vectors++;
            if (!ok || rsp !== 1'b0 || waits != ws_of(t) || rd !== 32'h5566AA00) begin
                miscompares++;
                $display("FAIL lanes dut%0d: got ok=%b resp=%b waits=%0d rdata=%h, want 1 0 %0d 5566aa00",
                         t, ok, rsp, waits, rd, ws_of(t));
            end
            last_rd[t] = 32'h5566AA00;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, ra, wd, rd, exp_rd;
        logic [2:0] sz;
        bit w_rsp, r_rsp, ok, err;
        int w_waits, r_waits;
        for (int t = 0; t < 2; t++) begin
            b2b(t, 32'h30, 3'd2, 32'h12345678, 32'h30, w_rsp, w_waits, rd, r_rsp, r_waits, ok);
            mdl_write(t, 32'h30, 3'd2, 32'h12345678);
            vectors++;
            if (!ok || w_rsp !== 1'b0 || r_rsp !== 1'b0 || rd !== 32'h12345678) begin
                miscompares++;
                $display("FAIL b2b_word dut%0d: got ok=%b wresp=%b rresp=%b rdata=%h, want 1 0 0 12345678",
                         t, ok, w_rsp, r_rsp, rd);
            end
            wd = ($urandom & 32'h00FFFFFF) | 32'hC3000000;
            b2b(t, 32'h33, 3'd0, wd, 32'h30, w_rsp, w_waits, rd, r_rsp, r_waits, ok);
            mdl_write(t, 32'h33, 3'd0, wd);
            vectors++;
            if (!ok || rd !== 32'hC3345678) begin
                miscompares++;
                $display("FAIL b2b_byte dut%0d: got ok=%b rdata=%h, want 1 c3345678", t, ok, rd);
            end
            last_rd[t] = 32'hC3345678;
            for (int i = 0; i < 15; i++) begin
                rand_req(a, sz);
                wd  = $urandom;
                ra  = ($urandom_range(0, 1) == 1) ? (a & 32'h000000FC) : 32'(4 * $urandom_range(0, NW - 1));
                err = exp_err(a, sz);
                if (!err) mdl_write(t, a, sz, wd);
                exp_rd = mdl[t][int'(ra >> 2)];
                b2b(t, a, sz, wd, ra, w_rsp, w_waits, rd, r_rsp, r_waits, ok);
                vectors++;
                if (!ok || w_rsp !== err || w_waits != (err ? 1 : ws_of(t)) || r_rsp !== 1'b0 ||
                    r_waits != ws_of(t) || rd !== exp_rd) begin
                    miscompares++;
                    $display("FAIL b2b_rand dut%0d #%0d wa=%h sz=%0d ra=%h: got ok=%b wresp=%b wwaits=%0d rresp=%b rwaits=%0d rdata=%h, want 1 %b %0d 0 %0d %h",
                             t, i, a, sz, ra, ok, w_rsp, w_waits, r_rsp, r_waits, rd,
                             err, err ? 1 : ws_of(t), ws_of(t), exp_rd);
                end
                last_rd[t] = exp_rd;
            end
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] rd;
        bit rsp, ok;
        int waits, ew;
        xfer(1, 1'b0, 32'h10, 3'd2, $urandom, rd, rsp, waits, ew, ok);
        vectors++;
        if (!ok || waits != 3 || ew != 0 || rsp !== 1'b0 || rd !== mdl[1][4]) begin
            miscompares++;
            $display("FAIL wait_states: got ok=%b waits=%0d errwaits=%0d resp=%b rdata=%h, want 1 3 0 0 %h",
                     ok, waits, ew, rsp, rd, mdl[1][4]);
        end
        last_rd[1] = mdl[1][4];
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        bit rsp, ok, w_rsp, r_rsp;
        int waits, ew, w_waits, r_waits;
        for (int t = 0; t < 2; t++) begin
            xfer(t, 1'b0, 32'h1000, 3'd2, $urandom, rd, rsp, waits, ew, ok);
            vectors++;
            if (!ok || rsp !== 1'b1 || waits != 1 || ew != 1 || rd !== last_rd[t]) begin
                miscompares++;
                $display("FAIL err_range dut%0d: got ok=%b resp=%b waits=%0d errwaits=%0d rdata=%h, want 1 1 1 1 %h",
                         t, ok, rsp, waits, ew, rd, last_rd[t]);
            end
            b2b(t, 32'h02, 3'd2, $urandom, 32'h00, w_rsp, w_waits, rd, r_rsp, r_waits, ok);
            vectors++;
            if (!ok || w_rsp !== 1'b1 || w_waits != 1 || r_rsp !== 1'b0 || r_waits != ws_of(t) ||
                rd !== mdl[t][0]) begin
                miscompares++;
                $display("FAIL err_misalign dut%0d: got ok=%b wresp=%b wwaits=%0d rresp=%b rwaits=%0d rdata=%h, want 1 1 1 0 %0d %h",
                         t, ok, w_rsp, w_waits, r_rsp, r_waits, rd, ws_of(t), mdl[t][0]);
            end
            last_rd[t] = mdl[t][0];
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] pre, rd;
        bit rsp, ok;
        int waits, ew;
        pre = mdl[1][16];
        addr_phase(1, 1'b1, 32'h40, 3'd2);
        @(posedge hclk); #1;
        bus_idle();
        hwdata = ~pre;
        @(posedge hclk); #1;
        hreset = 1'b1;
        @(posedge hclk); #1;
        hreset = 1'b0;
        @(negedge hclk);
        vectors++;
        if (rdy3 !== 1'b1 || resp3 !== 1'b0 || rdata3 !== 32'd0 || rdata0 !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_abort: got ready=%b resp=%b rdata=%h rdata0=%h, want 1 0 00000000 00000000",
                     rdy3, resp3, rdata3, rdata0);
        end
        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;
        @(posedge hclk); #1;
        xfer(1, 1'b0, 32'h40, 3'd2, $urandom, rd, rsp, waits, ew, ok);
        vectors++;
        if (!ok || rsp !== 1'b0 || waits != 3 || rd !== pre) begin
            miscompares++;
            $display("FAIL reset_abort_read: got ok=%b resp=%b waits=%0d rdata=%h, want 1 0 3 %h",
                     ok, rsp, waits, rd, pre);
        end
        last_rd[1] = pre;
    endtask

    task automatic rand_req(output logic [31:0] a, output logic [2:0] sz);
        int w;
        int kind;
        w    = $urandom_range(0, NW - 1);
        kind = $urandom_range(0, 9);
        sz   = 3'($urandom_range(0, 2));
        a    = 32'(w * 4);
        if (sz == 3'd0) a = a + 32'($urandom_range(0, 3));
        else if (sz == 3'd1) a = a + 32'(2 * $urandom_range(0, 1));
        if (kind == 0) begin
            sz = 3'($urandom_range(3, 7));
        end else if (kind == 1) begin
            a = 32'(DEPTH * 4) + ($urandom & 32'h0FFF_FFFC);
        end else if (kind == 2) begin
            sz = 3'($urandom_range(1, 2));
            a  = 32'(w * 4) + ((sz == 3'd1) ? 32'(1 + 2 * $urandom_range(0, 1)) : 32'($urandom_range(1, 3)));
        end
    endtask

    task automatic test_random();
        logic [31:0] a, wd, rd, exp_rd;
        logic [2:0] sz;
        bit wr, rsp, ok, err;
        int waits, ew, t;
        for (int i = 0; i < 80; i++) begin
            t  = i % 2;
            rand_req(a, sz);
            wr = ($urandom_range(0, 1) == 1);
            wd = $urandom;
            err = exp_err(a, sz);
            exp_rd = (err || wr) ? last_rd[t] : mdl[t][int'(a >> 2)];
            xfer(t, wr, a, sz, wd, rd, rsp, waits, ew, ok);
            vectors++;
            if (!ok || rsp !== err || waits != (err ? 1 : ws_of(t)) || ew != (err ? 1 : 0) ||
                rd !== exp_rd) begin
                miscompares++;
                $display("FAIL rand dut%0d #%0d addr=%h size=%0d wr=%b: got ok=%b resp=%b waits=%0d errwaits=%0d rdata=%h, want 1 %b %0d %0d %h",
                         t, i, a, sz, wr, ok, rsp, waits, ew, rd,
                         err, err ? 1 : ws_of(t), err ? 1 : 0, exp_rd);
            end
            if (!err && wr) mdl_write(t, a, sz, wd);
            last_rd[t] = exp_rd;
        end
    endtask

    initial begin
        hreset = 1'b1;
        hsel   = 2'b00;
        haddr  = 32'd0;
        hwdata = 32'd0;
        hwrite = 1'b0;
        hsize  = 3'd2;
        hburst = 3'd0;
        htrans = 2'b00;
        test_reset();
        test_init();
        test_word_rw();
        test_lanes();
        test_back_to_back();
        test_wait_states();
        test_errors();
        test_reset_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
